// File: rtl/shifter_pkg.sv
// Shared definitions for the pipelined barrel shifter: op encodings and
// the helper that splits the shift amount into per-stage bit groups.
package shifter_pkg;

  typedef logic [1:0] shift_op_t;

  localparam shift_op_t OP_SLL = 2'b00;
  localparam shift_op_t OP_SRL = 2'b01;
  localparam shift_op_t OP_SRA = 2'b10;
  localparam shift_op_t OP_ROL = 2'b11;

  // Number of shamt bits resolved per stage; the last stage takes what is left.
  function automatic int stage_bits(input int stages, input int shamt_w);
    return (shamt_w + stages - 1) / stages;
  endfunction

endpackage

// File: rtl/shift_stage.sv
// One registered shifter stage: applies shamt bits [LO_BIT +: NBITS] and
// holds the result behind a valid/ready slice. ROL is built only with SHIFTER_ROTATE_EN.
module shift_stage
  import shifter_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = $clog2(WIDTH),
  parameter int LO_BIT  = 0,
  parameter int NBITS   = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               up_valid,
  output logic               up_ready,
  input  logic [WIDTH-1:0]   up_data,
  input  shift_op_t          up_op,
  input  logic [SHAMT_W-1:0] up_shamt,
  output logic               dn_valid,
  input  logic               dn_ready,
  output logic [WIDTH-1:0]   dn_data,
  output shift_op_t          dn_op,
  output logic [SHAMT_W-1:0] dn_shamt
);

  logic [WIDTH-1:0] shifted;

  // Handshake: a transfer happens on valid && ready at either side. The
  // slice accepts whenever it is empty or its content leaves this cycle,
  // so bubbles are squeezed out even while the tail is stalled.
  assign up_ready = !dn_valid || dn_ready;

  // Arithmetic right shift keeps the MSB, so the sign survives every stage.
  always_comb begin
    shifted = up_data;
    for (int i = 0; i < SHAMT_W; i++) begin
      if (i >= LO_BIT && i < LO_BIT + NBITS && up_shamt[i]) begin
        case (up_op)
          OP_SRL: shifted = shifted >> (1 << i);
          OP_SRA: shifted = WIDTH'($signed(shifted) >>> (1 << i));
`ifdef SHIFTER_ROTATE_EN
          OP_ROL: shifted = (shifted << (1 << i)) | (shifted >> (WIDTH - (1 << i)));
`endif
          default: shifted = shifted << (1 << i);
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dn_valid <= 1'b0;
      dn_data  <= '0;
      dn_op    <= OP_SLL;
      dn_shamt <= '0;
    end else if (up_ready) begin
      dn_valid <= up_valid;
      if (up_valid) begin
        dn_data  <= shifted;
        dn_op    <= up_op;
        dn_shamt <= up_shamt;
      end
    end
  end

endmodule

// File: rtl/pipe_shifter.sv
// Pipelined barrel shifter (SLL/SRL/SRA/ROL) with valid/ready backpressure.
// Define SHIFTER_ROTATE_EN to build rotate-left; otherwise op=11 acts as SLL.
module pipe_shifter
  import shifter_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = $clog2(WIDTH),
  parameter int STAGES  = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_data,
  input  logic [SHAMT_W-1:0] in_shamt,
  input  shift_op_t          in_op,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_data
);

  localparam int GROUP = stage_bits(STAGES, SHAMT_W);

  // Index k is the input side of stage k; index STAGES is the pipeline output.
  logic               valid_p [0:STAGES];
  logic               ready_p [0:STAGES];
  logic [WIDTH-1:0]   data_p  [0:STAGES];
  shift_op_t          op_p    [0:STAGES];
  logic [SHAMT_W-1:0] shamt_p [0:STAGES];

  assign valid_p[0]      = in_valid;
  assign data_p[0]       = in_data;
  assign op_p[0]         = in_op;
  assign shamt_p[0]      = in_shamt;
  assign in_ready        = ready_p[0];
  assign ready_p[STAGES] = out_ready;
  assign out_valid       = valid_p[STAGES];
  assign out_data        = data_p[STAGES];

  // Op and shamt are not needed past the final stage.
  logic unused_tail;
  assign unused_tail = ^{op_p[STAGES], shamt_p[STAGES]};

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int LO   = k * GROUP;
    localparam int LEFT = SHAMT_W - LO;
    localparam int NB   = (LEFT <= 0) ? 0 : ((LEFT < GROUP) ? LEFT : GROUP);

    shift_stage #(
      .WIDTH   (WIDTH),
      .SHAMT_W (SHAMT_W),
      .LO_BIT  (LO),
      .NBITS   (NB)
    ) u_stage (
      .clk      (clk),
      .reset    (reset),
      .up_valid (valid_p[k]),
      .up_ready (ready_p[k]),
      .up_data  (data_p[k]),
      .up_op    (op_p[k]),
      .up_shamt (shamt_p[k]),
      .dn_valid (valid_p[k+1]),
      .dn_ready (ready_p[k+1]),
      .dn_data  (data_p[k+1]),
      .dn_op    (op_p[k+1]),
      .dn_shamt (shamt_p[k+1])
    );
  end

endmodule

// File: tb/tb_pipe_shifter.sv
// Directed bench for pipe_shifter: behavioural model + scoreboard queue,
// literal expectations, streaming, stall and async-reset scenarios.
module tb_pipe_shifter;

  localparam int W      = 32;
  localparam int SW     = 5;
  localparam int STAGES = 2;

  logic          clk       = 1'b0;
  logic          reset     = 1'b1;
  logic          in_valid  = 1'b0;
  logic          in_ready;
  logic [W-1:0]  in_data   = '0;
  logic [SW-1:0] in_shamt  = '0;
  logic [1:0]    in_op     = 2'b00;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [W-1:0]  out_data;

  pipe_shifter #(.WIDTH(W), .STAGES(STAGES)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_shamt  (in_shamt),
    .in_op     (in_op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;
  always @(posedge clk) cyc++;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d", n_errors);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [W-1:0] model(input logic [W-1:0] d, input int sh, input logic [1:0] op);
    logic [W-1:0]   r;
    logic [2*W-1:0] dd;
    r = d;
    case (op)
      2'b00: r = d << sh;
      2'b01: r = d >> sh;
      2'b10: begin
        r = d >> sh;
        for (int i = 0; i < sh; i++) r[W-1-i] = d[W-1];
      end
      default: begin
`ifdef SHIFTER_ROTATE_EN
        dd = {d, d} << sh;
        r  = dd[2*W-1:W];
`else
        dd = '0;
        r  = d << sh;
`endif
      end
    endcase
    return r;
  endfunction

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  int           out_cyc_q[$];
  logic         held_v = 1'b0;
  logic [W-1:0] held_d = '0;

  always @(negedge clk) begin
    if (reset) begin
      exp_q.delete();
      held_v = 1'b0;
    end else begin
      if (held_v) begin
        check("hold_valid", {63'd0, out_valid}, 64'd1);
        check("hold_data", {32'd0, out_data}, {32'd0, held_d});
      end
      if (in_valid && in_ready)
        exp_q.push_back(model(in_data, int'(in_shamt), in_op));
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) check("unexpected_out", {63'd0, out_valid}, 64'd0);
        else check("sb_data", {32'd0, out_data}, {32'd0, exp_q.pop_front()});
        out_cyc_q.push_back(cyc);
      end
      held_v = out_valid && !out_ready;
      held_d = out_data;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send(input logic [W-1:0] d, input int sh, input logic [1:0] op, output int waited);
    logic done;
    done     = 1'b0;
    waited   = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_shamt = SW'(sh);
    in_op    = op;
    for (int t = 0; t < 50 && !done; t++) begin
      @(negedge clk);
      if (in_ready) done = 1'b1;
      else waited++;
      @(posedge clk);
      #1;
    end
    if (!done) check("send_timeout", {63'd0, in_ready}, 64'd1);
  endtask

  task automatic run_one(input string name, input logic [W-1:0] d, input int sh,
                         input logic [1:0] op, input logic [W-1:0] exp);
    int   lat;
    int   w;
    logic got;
    check({name, "_model"}, {32'd0, model(d, sh, op)}, {32'd0, exp});
    out_ready = 1'b1;
    send(d, sh, op, w);
    in_valid = 1'b0;
    lat = 1;
    got = 1'b0;
    for (int t = 0; t < 20 && !got; t++) begin
      @(negedge clk);
      if (out_valid) got = 1'b1;
      else begin
        @(posedge clk);
        lat++;
      end
    end
    check({name, "_lat"}, 64'(lat), 64'(STAGES));
    check({name, "_data"}, {32'd0, out_data}, {32'd0, exp});
    @(posedge clk);
    #1;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int w;
    int n0;
    int accepted;
    logic acc;
    logic [W-1:0] stall_d [6];

    repeat (2) @(negedge clk);
    check("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("rst_out_data", {32'd0, out_data}, 64'd0);
    check("rst_in_ready", {63'd0, in_ready}, 64'd1);
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk);
    #1;

    run_one("sll_1_2", 32'h0000_0001, 2, 2'b00, 32'h0000_0004);
    run_one("srl_msb_31", 32'h8000_0000, 31, 2'b01, 32'h0000_0001);
    run_one("sra_neg_4", 32'h8000_0000, 4, 2'b10, 32'hF800_0000);
    run_one("sra_pos_4", 32'h7FFF_FFFF, 4, 2'b10, 32'h07FF_FFFF);
    run_one("sra_ones_31", 32'hFFFF_FFFF, 31, 2'b10, 32'hFFFF_FFFF);
    run_one("sra_neg_31", 32'h8000_0000, 31, 2'b10, 32'hFFFF_FFFF);
    run_one("sll_3_31", 32'h0000_0003, 31, 2'b00, 32'h8000_0000);
    run_one("sh0_sll", 32'h1234_5678, 0, 2'b00, 32'h1234_5678);
    run_one("sh0_srl", 32'h1234_5678, 0, 2'b01, 32'h1234_5678);
    run_one("sh0_sra", 32'h1234_5678, 0, 2'b10, 32'h1234_5678);
    run_one("sh0_rol", 32'h1234_5678, 0, 2'b11, 32'h1234_5678);
`ifdef SHIFTER_ROTATE_EN
    run_one("rol_1", 32'h8000_0001, 1, 2'b11, 32'h0000_0003);
    run_one("rol_8", 32'h1234_5678, 8, 2'b11, 32'h3456_7812);
`else
    run_one("rol_1", 32'h8000_0001, 1, 2'b11, 32'h0000_0002);
    run_one("rol_8", 32'h1234_5678, 8, 2'b11, 32'h3456_7800);
`endif

    // Streaming: eight back-to-back ops, one result per cycle.
    out_ready = 1'b1;
    n0 = out_cyc_q.size();
    for (int i = 1; i <= 8; i++) begin
      send(32'h0101_0101 * i, i, 2'(i % 4), w);
      check("stream_no_wait", 64'(w), 64'd0);
    end
    in_valid = 1'b0;
    repeat (STAGES + 3) @(posedge clk);
    #1;
    check("stream_count", 64'(out_cyc_q.size() - n0), 64'd8);
    if (out_cyc_q.size() >= n0 + 8)
      check("stream_span", 64'(out_cyc_q[n0 + 7] - out_cyc_q[n0]), 64'd7);

    // Stall: consumer blocked for 5 cycles while inputs keep coming.
    for (int j = 0; j < 6; j++) stall_d[j] = 32'hA5A5_0000 + 32'(j * 17);
    out_ready = 1'b0;
    n0 = out_cyc_q.size();
    accepted = 0;
    in_valid = 1'b1;
    in_data = stall_d[0];
    in_shamt = 5'd1;
    in_op = 2'b00;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      if (acc) begin
        accepted++;
        in_data = stall_d[accepted];
        in_shamt = SW'(accepted + 1);
        in_op = 2'(accepted % 3);
      end
    end
    check("stall_accepts", 64'(accepted), 64'(STAGES));
    @(negedge clk);
    check("stall_in_ready", {63'd0, in_ready}, 64'd0);
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    for (int c = 0; c < 40 && accepted < 6; c++) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      if (acc) begin
        accepted++;
        if (accepted < 6) begin
          in_data = stall_d[accepted];
          in_shamt = SW'(accepted + 1);
          in_op = 2'(accepted % 3);
        end
      end
    end
    in_valid = 1'b0;
    for (int c = 0; c < 20 && exp_q.size() != 0; c++) @(posedge clk);
    #1;
    check("stall_drain", 64'(exp_q.size()), 64'd0);
    check("stall_count", 64'(out_cyc_q.size() - n0), 64'd6);

    // Async reset with two ops in flight.
    out_ready = 1'b0;
    send(32'h0000_00F0, 4, 2'b00, w);
    send(32'h0000_0F00, 4, 2'b01, w);
    in_valid = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    check("arst_out_valid", {63'd0, out_valid}, 64'd0);
    check("arst_out_data", {32'd0, out_data}, 64'd0);
    check("arst_in_ready", {63'd0, in_ready}, 64'd1);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    out_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check("post_rst_idle", {63'd0, out_valid}, 64'd0);
    end
    @(posedge clk);
    #1;
    run_one("post_rst_sll", 32'h0000_0002, 2, 2'b00, 32'h0000_0008);

    repeat (2) @(posedge clk);
    #1;
    check("final_queue_empty", 64'(exp_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
